// File: rtl/led_bus_ctrl.sv
// Memory-mapped LED controller on an Ibex-style data bus with set/clear/toggle aliases.
// Optional blink engine (BLINK_MASK, BLINK_PERIOD) is built only with LED_BUS_CTRL_BLINK_EN.
module led_bus_ctrl #(
  parameter int unsigned NumLeds    = 4,
  parameter int unsigned PrescWidth = 24
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               req_i,
  input  logic               we_i,
  input  logic [3:0]         be_i,
  input  logic [31:0]        addr_i,
  input  logic [31:0]        wdata_i,
  output logic               gnt_o,
  output logic               rvalid_o,
  output logic [31:0]        rdata_o,
  output logic               err_o,
  output logic [NumLeds-1:0] led_o
);

  localparam logic [5:0] OffOut = 6'h00;
  localparam logic [5:0] OffSet = 6'h01;
  localparam logic [5:0] OffClr = 6'h02;
  localparam logic [5:0] OffTgl = 6'h03;
`ifdef LED_BUS_CTRL_BLINK_EN
  localparam logic [5:0] OffMask   = 6'h04;
  localparam logic [5:0] OffPeriod = 6'h05;
`endif

  logic [5:0]         w_off;
  logic [31:0]        w_bmask;
  logic [31:0]        w_wbits;
  logic               w_wr;
  logic               w_rd;
  logic               w_hit;
  logic [31:0]        w_rdata_d;
  logic [NumLeds-1:0] w_out_d;
  logic [NumLeds-1:0] r_out;
  logic               r_rvalid;
  logic               r_err;
  logic [31:0]        r_rdata;
  logic               w_unused;

  assign w_off   = addr_i[7:2];
  assign w_bmask = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
  assign w_wbits = wdata_i & w_bmask;
  assign w_wr    = req_i & we_i;
  assign w_rd    = req_i & ~we_i;
  assign gnt_o   = req_i;

  // Bits outside the decoded address and the stored register widths are ignored.
  assign w_unused = ^{addr_i[31:8], addr_i[1:0], w_wbits, w_bmask};

`ifdef LED_BUS_CTRL_BLINK_EN
  logic [NumLeds-1:0]    r_mask;
  logic [NumLeds-1:0]    w_mask_d;
  logic [PrescWidth-1:0] r_period;
  logic [PrescWidth-1:0] w_period_d;
  logic [PrescWidth-1:0] r_cnt;
  logic                  r_phase;
  logic                  w_period_wr;

  assign w_period_wr = w_wr && (w_off == OffPeriod) && (be_i != 4'b0);
`endif

  always_comb begin
    w_hit     = 1'b0;
    w_rdata_d = '0;
    w_out_d   = r_out;
`ifdef LED_BUS_CTRL_BLINK_EN
    w_mask_d   = r_mask;
    w_period_d = r_period;
`endif
    case (w_off)
      OffOut: begin
        w_hit     = 1'b1;
        w_rdata_d = 32'(r_out);
        if (w_wr) w_out_d = (r_out & ~w_bmask[NumLeds-1:0]) | w_wbits[NumLeds-1:0];
      end
      OffSet: begin
        w_hit = 1'b1;
        if (w_wr) w_out_d = r_out | w_wbits[NumLeds-1:0];
      end
      OffClr: begin
        w_hit = 1'b1;
        if (w_wr) w_out_d = r_out & ~w_wbits[NumLeds-1:0];
      end
      OffTgl: begin
        w_hit = 1'b1;
        if (w_wr) w_out_d = r_out ^ w_wbits[NumLeds-1:0];
      end
`ifdef LED_BUS_CTRL_BLINK_EN
      OffMask: begin
        w_hit     = 1'b1;
        w_rdata_d = 32'(r_mask);
        if (w_wr) w_mask_d = (r_mask & ~w_bmask[NumLeds-1:0]) | w_wbits[NumLeds-1:0];
      end
      OffPeriod: begin
        w_hit     = 1'b1;
        w_rdata_d = 32'(r_period);
        if (w_wr) begin
          w_period_d = (r_period & ~w_bmask[PrescWidth-1:0]) | w_wbits[PrescWidth-1:0];
        end
      end
`endif
      default: w_hit = 1'b0;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_out    <= '0;
      r_rvalid <= 1'b0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_out    <= w_out_d;
      r_rvalid <= req_i;
      r_err    <= req_i & ~w_hit;
      r_rdata  <= (w_rd && w_hit) ? w_rdata_d : '0;
    end
  end

`ifdef LED_BUS_CTRL_BLINK_EN
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      r_mask   <= '0;
      r_period <= '0;
      r_cnt    <= '0;
      r_phase  <= 1'b0;
    end else begin
      r_mask   <= w_mask_d;
      r_period <= w_period_d;
      // A period write restarts the blink sequence even if a wrap was due.
      if (w_period_wr || (r_period == '0)) begin
        r_cnt   <= '0;
        r_phase <= 1'b0;
      end else if (r_cnt == r_period) begin
        r_cnt   <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_cnt <= r_cnt + PrescWidth'(1);
      end
    end
  end

  assign led_o = r_out ^ (r_mask & {NumLeds{r_phase}});
`else
  assign led_o = r_out;
`endif

  assign rvalid_o = r_rvalid;
  assign err_o    = r_err;
  assign rdata_o  = r_rdata;

endmodule

// File: tb/tb_led_bus_ctrl.sv
// Self-checking bench for led_bus_ctrl: directed bus steps plus random accesses against a
// register-level reference model; blink expectations derived from elapsed cycles.
module tb_led_bus_ctrl;

  localparam int unsigned NumLeds    = 4;
  localparam int unsigned PrescWidth = 24;
  localparam logic [31:0] LedMask = (NumLeds == 32) ? 32'hFFFF_FFFF : ((32'd1 << NumLeds) - 32'd1);
  localparam logic [31:0] PerMask = (PrescWidth == 32) ? 32'hFFFF_FFFF :
                                    ((32'd1 << PrescWidth) - 32'd1);
`ifdef LED_BUS_CTRL_BLINK_EN
  localparam bit BlinkEn = 1'b1;
`else
  localparam bit BlinkEn = 1'b0;
`endif

  logic               clk_i = 1'b0;
  logic               rst_ni;
  logic               req_i;
  logic               we_i;
  logic [3:0]         be_i;
  logic [31:0]        addr_i;
  logic [31:0]        wdata_i;
  logic               gnt_o;
  logic               rvalid_o;
  logic [31:0]        rdata_o;
  logic               err_o;
  logic [NumLeds-1:0] led_o;

  led_bus_ctrl #(
    .NumLeds   (NumLeds),
    .PrescWidth(PrescWidth)
  ) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .req_i   (req_i),
    .we_i    (we_i),
    .be_i    (be_i),
    .addr_i  (addr_i),
    .wdata_i (wdata_i),
    .gnt_o   (gnt_o),
    .rvalid_o(rvalid_o),
    .rdata_o (rdata_o),
    .err_o   (err_o),
    .led_o   (led_o)
  );

  always #5 clk_i = ~clk_i;

  int unsigned cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  // Reference model state.
  logic [31:0] m_out, m_mask, m_period;
  int unsigned m_clear;
  int errors = 0;
  int checks = 0;

  function automatic logic [31:0] led_exp();
    logic [31:0] ph;
    ph = '0;
    if (BlinkEn && (m_period != 0)) begin
      if ((((cyc - m_clear) / (m_period + 32'd1)) % 2) == 1) ph = '1;
    end
    return m_out ^ (m_mask & ph);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_access(input logic we, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wd, output logic exp_err,
                              output logic [31:0] exp_rdata, output logic clr);
    int unsigned off;
    logic [31:0] bm;
    logic        mapped;
    off = (addr >> 2) % 64;
    bm  = '0;
    for (int i = 0; i < 4; i++) if (be[i]) bm = bm | (32'hFF << (8 * i));
    mapped    = (off <= 3) || (BlinkEn && (off <= 5));
    exp_err   = !mapped;
    exp_rdata = '0;
    clr       = 1'b0;
    if (mapped && !we) begin
      if (off == 0) exp_rdata = m_out;
      else if (off == 4) exp_rdata = m_mask;
      else if (off == 5) exp_rdata = m_period;
    end
    if (mapped && we) begin
      case (off)
        0: m_out = ((m_out & ~bm) | (wd & bm)) & LedMask;
        1: m_out = m_out | (wd & bm & LedMask);
        2: m_out = m_out & ~(wd & bm);
        3: m_out = m_out ^ (wd & bm & LedMask);
        4: m_mask = ((m_mask & ~bm) | (wd & bm)) & LedMask;
        default: begin
          m_period = ((m_period & ~bm) | (wd & bm)) & PerMask;
          clr = (be != 4'b0);
        end
      endcase
    end
  endtask

  // Entered and left at 1 time unit after a rising edge.
  task automatic bus_op(input string tag, input logic we, input logic [31:0] addr,
                        input logic [3:0] be, input logic [31:0] wd);
    logic        e;
    logic [31:0] r;
    logic        clr;
    req_i = 1'b1; we_i = we; addr_i = addr; be_i = be; wdata_i = wd;
    #1;
    check({tag, ".gnt"}, 32'(gnt_o), 32'd1);
    model_access(we, addr, be, wd, e, r, clr);
    @(posedge clk_i);
    #1;
    if (clr) m_clear = cyc;
    req_i = 1'b0; we_i = 1'b0;
    check({tag, ".rvalid"}, 32'(rvalid_o), 32'd1);
    check({tag, ".err"}, 32'(err_o), 32'(e));
    check({tag, ".rdata"}, rdata_o, r);
    check({tag, ".led"}, 32'(led_o), led_exp());
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_i);
      #1;
      check({tag, ".rvalid"}, 32'(rvalid_o), 32'd0);
      check({tag, ".rdata"}, rdata_o, 32'd0);
      check({tag, ".led"}, 32'(led_o), led_exp());
    end
  endtask

  initial begin
    logic [31:0] ra, wd;
    int unsigned off;
    m_out = '0; m_mask = '0; m_period = '0; m_clear = 0;
    rst_ni = 1'b0; req_i = 1'b0; we_i = 1'b0; be_i = '0; addr_i = '0; wdata_i = '0;

    // Reset with a write presented: granted but ignored.
    @(posedge clk_i);
    #1;
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h0; be_i = 4'hF; wdata_i = 32'hF;
    #1;
    check("rst.gnt", 32'(gnt_o), 32'd1);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; we_i = 1'b0;
    check("rst.rvalid", 32'(rvalid_o), 32'd0);
    check("rst.rdata", rdata_o, 32'd0);
    check("rst.led", 32'(led_o), 32'd0);
    rst_ni = 1'b1;
    idle("post_rst", 1);
    bus_op("rst.out_rd", 1'b0, 32'h0, 4'hF, 32'h0);

    // Basic write/read, then set/clear/toggle aliases.
    bus_op("out_wr", 1'b1, 32'h00, 4'hF, 32'h5);
    bus_op("out_rd", 1'b0, 32'h00, 4'hF, 32'h0);
    bus_op("set_wr", 1'b1, 32'h04, 4'hF, 32'h2);
    bus_op("clr_wr", 1'b1, 32'h08, 4'hF, 32'h1);
    bus_op("tgl_wr", 1'b1, 32'h0C, 4'hF, 32'hC);
    bus_op("set_rd", 1'b0, 32'h04, 4'hF, 32'h0);
    check("tgl.led_abs", 32'(led_o), 32'hA);

    // Byte enables and unmapped offsets.
    bus_op("out_clr", 1'b1, 32'h00, 4'hF, 32'h0);
    bus_op("out_be2", 1'b1, 32'h00, 4'h2, 32'hF);
    bus_op("out_rd2", 1'b0, 32'h00, 4'hF, 32'h0);
    bus_op("out_be0", 1'b1, 32'h00, 4'h0, 32'hF);
    bus_op("unmap_rd", 1'b0, 32'h18, 4'hF, 32'h0);
    bus_op("alias_wr", 1'b1, 32'h0000_0103, 4'h1, 32'h3);
    idle("gap", 1);

`ifdef LED_BUS_CTRL_BLINK_EN
    bus_op("mask_wr", 1'b1, 32'h10, 4'hF, 32'h1);
    bus_op("per_wr", 1'b1, 32'h14, 4'hF, 32'h3);
    idle("blink", 10);
    bus_op("per_zero", 1'b1, 32'h14, 4'hF, 32'h0);
    idle("steady", 4);
    bus_op("per_wide", 1'b1, 32'h14, 4'hF, 32'hFFFF_FFFF);
    bus_op("per_wide_rd", 1'b0, 32'h14, 4'hF, 32'h0);
    bus_op("per_two", 1'b1, 32'h14, 4'h1, 32'h2);
    idle("blink2", 5);
`else
    bus_op("noblink_wr", 1'b1, 32'h10, 4'hF, 32'h1);
    bus_op("noblink_per", 1'b1, 32'h14, 4'hF, 32'h3);
    idle("noblink", 3);
`endif

    // Reset mid-blink with a read outstanding.
    req_i = 1'b1; we_i = 1'b0; addr_i = 32'h0; be_i = 4'hF; rst_ni = 1'b0;
    #1;
    check("rst2.gnt", 32'(gnt_o), 32'd1);
    @(posedge clk_i);
    #1;
    req_i = 1'b0; rst_ni = 1'b1;
    m_out = '0; m_mask = '0; m_period = '0; m_clear = cyc;
    check("rst2.rvalid", 32'(rvalid_o), 32'd0);
    check("rst2.led", 32'(led_o), 32'd0);
    idle("rst2.idle", 2);
    bus_op("rst2.out", 1'b0, 32'h00, 4'hF, 32'h0);
    bus_op("rst2.mask", 1'b0, 32'h10, 4'hF, 32'h0);
    bus_op("rst2.per", 1'b0, 32'h14, 4'hF, 32'h0);

    // Random accesses, including back-to-back runs and aliased upper address bits.
    for (int n = 0; n < 80; n++) begin
      ra  = $urandom();
      off = $urandom_range(0, 7);
      if (off >= 6) off = $urandom_range(6, 63);
      wd = $urandom();
      if (off == 5) wd = $urandom_range(0, 5);
      bus_op("rand", 1'($urandom_range(0, 1)), {ra[31:8], 6'(off), ra[1:0]},
             4'($urandom_range(0, 15)), wd);
      if ($urandom_range(0, 2) == 0) idle("rand.idle", int'($urandom_range(1, 4)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
